// File: rtl/alu_sequencer.sv
// alu_sequencer: operands and opcode are loaded from a switch bank through a
// single synchronised "enter" button. A load FSM captures A, B and OP, then
// runs one registered ALU operation and pulses o_valid for one cycle.
// Optional build macro: ALU_SAT_EN (saturate ADD/SUB on signed overflow).
//
// state   | meaning
// --------+-------------------------------------------------
// LOAD_A  | waiting for enter to capture operand A
// LOAD_B  | waiting for enter to capture operand B
// LOAD_OP | waiting for enter to capture the opcode
// EXEC    | one cycle: register result and flags, pulse valid
module alu_sequencer #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6,
    parameter int NB_SYNC = 2
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic [NB_DATA-1:0]        i_switches,
    input  logic                      i_enter,
    output logic signed [NB_DATA-1:0] o_resultado,
    output logic                      o_zero,
    output logic                      o_carry,
    output logic                      o_overflow,
    output logic                      o_valid,
    output logic [1:0]                o_state
);

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        LOAD_OP = 2'd2,
        EXEC    = 2'd3
    } state_t;

    localparam int MSB = NB_DATA - 1;
    localparam logic [NB_DATA-1:0] SHIFT_LIM = NB_DATA'(NB_DATA);

    localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);
    localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'b100010);
    localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'b100100);
    localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'b100101);
    localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'b100110);
    localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'b100111);
    localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'b000011);
    localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'b000010);

    logic [NB_SYNC-1:0] sync_q;
    logic [NB_SYNC-1:0] fill_q;
    logic               synced_d_q;
    logic               armed_q;
    logic               synced;
    logic               enter_evt;

    state_t             state_q, state_d;
    logic [NB_DATA-1:0] a_q, a_d;
    logic [NB_DATA-1:0] b_q, b_d;
    logic [NB_OP-1:0]   op_q, op_d;
    logic [NB_DATA-1:0] res_q, res_d;
    logic               zero_q, zero_d;
    logic               carry_q, carry_d;
    logic               ovf_q, ovf_d;
    logic               valid_q, valid_d;

    logic [NB_DATA:0]   sum;
    logic [NB_DATA:0]   diff;
    logic [NB_DATA-1:0] alu_res;
    logic [NB_DATA-1:0] alu_final;
    logic               alu_c;
    logic               alu_v;

    assign synced = sync_q[NB_SYNC-1];
    // Edges only count once the chain holds real samples and the button has
    // been seen released, so a press held through reset is ignored.
    assign enter_evt = armed_q & synced & ~synced_d_q;

    // Button synchroniser, edge-detect history and post-reset arming.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            sync_q     <= '0;
            fill_q     <= '0;
            synced_d_q <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            sync_q     <= {sync_q[NB_SYNC-2:0], i_enter};
            fill_q     <= {fill_q[NB_SYNC-2:0], 1'b1};
            synced_d_q <= synced;
            armed_q    <= armed_q | (fill_q[NB_SYNC-1] & ~synced);
        end
    end

    assign sum  = {1'b0, a_q} + {1'b0, b_q};
    assign diff = {1'b0, a_q} - {1'b0, b_q};

    // ALU datapath: raw result, carry/borrow and signed overflow.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_res = sum[NB_DATA-1:0];
                alu_c   = sum[NB_DATA];
                alu_v   = (a_q[MSB] == b_q[MSB]) && (sum[MSB] != a_q[MSB]);
            end
            OP_SUB: begin
                alu_res = diff[NB_DATA-1:0];
                alu_c   = diff[NB_DATA];
                alu_v   = (a_q[MSB] != b_q[MSB]) && (diff[MSB] != a_q[MSB]);
            end
            OP_AND: alu_res = a_q & b_q;
            OP_OR:  alu_res = a_q | b_q;
            OP_XOR: alu_res = a_q ^ b_q;
            OP_NOR: alu_res = ~(a_q | b_q);
            OP_SRA: begin
                if (b_q >= SHIFT_LIM) alu_res = {NB_DATA{a_q[MSB]}};
                else                  alu_res = $signed(a_q) >>> b_q;
            end
            OP_SRL: begin
                if (b_q >= SHIFT_LIM) alu_res = '0;
                else                  alu_res = a_q >> b_q;
            end
            default: alu_res = '0;
        endcase
    end

`ifdef ALU_SAT_EN
    // Overflow direction follows A's sign for both ADD and SUB.
    assign alu_final = alu_v ? (a_q[MSB] ? {1'b1, {(NB_DATA-1){1'b0}}}
                                         : {1'b0, {(NB_DATA-1){1'b1}}})
                             : alu_res;
`else
    assign alu_final = alu_res;
`endif

    // Load FSM next state, operand capture and result update in EXEC.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;
        case (state_q)
            LOAD_A: if (enter_evt) begin
                a_d     = i_switches;
                state_d = LOAD_B;
            end
            LOAD_B: if (enter_evt) begin
                b_d     = i_switches;
                state_d = LOAD_OP;
            end
            LOAD_OP: if (enter_evt) begin
                op_d    = i_switches[NB_OP-1:0];
                state_d = EXEC;
            end
            EXEC: begin
                res_d   = alu_final;
                zero_d  = (alu_final == '0);
                carry_d = alu_c;
                ovf_d   = alu_v;
                valid_d = 1'b1;
                state_d = LOAD_A;
            end
            default: state_d = LOAD_A;
        endcase
    end

    // State, operand and output registers.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= LOAD_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign o_resultado = res_q;
    assign o_zero      = zero_q;
    assign o_carry     = carry_q;
    assign o_overflow  = ovf_q;
    assign o_valid     = valid_q;
    assign o_state     = state_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer (NB_DATA=8, NB_OP=6, NB_SYNC=2).
module tb_alu_sequencer;

    logic              clk;
    logic              rst_n;
    logic [7:0]        sw;
    logic              enter;
    logic signed [7:0] res;
    logic              zero, carry, ovf, valid;
    logic [1:0]        st;

    int n_cmp = 0;
    int n_err = 0;
    int vfirst;
    int vcount;
    logic [1:0] st_at_valid;

    alu_sequencer #(.NB_DATA(8), .NB_OP(6), .NB_SYNC(2)) dut (
        .i_clock     (clk),
        .i_reset     (rst_n),
        .i_switches  (sw),
        .i_enter     (enter),
        .o_resultado (res),
        .o_zero      (zero),
        .o_carry     (carry),
        .o_overflow  (ovf),
        .o_valid     (valid),
        .o_state     (st)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    task automatic press(input logic [7:0] v);
        @(negedge clk);
        sw = v;
        enter = 1'b1;
        repeat (4) @(negedge clk);
        enter = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Press that triggers EXEC; records when and how long o_valid is high.
    task automatic press_exec(input logic [7:0] v);
        @(negedge clk);
        sw = v;
        enter = 1'b1;
        vfirst = 0;
        vcount = 0;
        st_at_valid = 2'd3;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (valid === 1'b1) begin
                vcount++;
                if (vfirst == 0) begin
                    vfirst = i;
                    st_at_valid = st;
                end
            end
        end
        enter = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        press(a);
        press(b);
        press_exec(op);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        enter = 1'b0;
        sw = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++; if (st !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d expected 0", st); end
        n_cmp++; if (res !== 8'h00) begin n_err++; $display("FAIL reset_res: got %h expected 00", res); end
        n_cmp++; if ({zero, carry, ovf, valid} !== 4'b0000) begin n_err++; $display("FAIL reset_flags: got %b expected 0000", {zero, carry, ovf, valid}); end
    endtask

    task automatic test_add_basic;
        run_op(8'h05, 8'h03, 8'b00100000);
        n_cmp++; if (res !== 8'h08) begin n_err++; $display("FAIL add_res: got %h expected 08", res); end
        n_cmp++; if ({zero, carry, ovf} !== 3'b000) begin n_err++; $display("FAIL add_flags: got %b expected 000", {zero, carry, ovf}); end
        n_cmp++; if (vfirst !== 4) begin n_err++; $display("FAIL add_latency: got %0d expected 4", vfirst); end
        n_cmp++; if (vcount !== 1) begin n_err++; $display("FAIL add_pulse: got %0d expected 1", vcount); end
        n_cmp++; if (st_at_valid !== 2'd0) begin n_err++; $display("FAIL add_state_at_valid: got %0d expected 0", st_at_valid); end
    endtask

    task automatic test_add_overflow;
        logic [7:0] exp_res;
`ifdef ALU_SAT_EN
        exp_res = 8'h7F;
`else
        exp_res = 8'h80;
`endif
        run_op(8'h7F, 8'h01, 8'h20);
        n_cmp++; if (res !== exp_res) begin n_err++; $display("FAIL ovf_res: got %h expected %h", res, exp_res); end
        n_cmp++; if ({zero, carry, ovf} !== 3'b001) begin n_err++; $display("FAIL ovf_flags: got %b expected 001", {zero, carry, ovf}); end
    endtask

    task automatic test_sub;
        run_op(8'h03, 8'h05, 8'h22);
        n_cmp++; if (res !== 8'hFE) begin n_err++; $display("FAIL sub_res: got %h expected FE", res); end
        n_cmp++; if ({zero, carry, ovf} !== 3'b010) begin n_err++; $display("FAIL sub_flags: got %b expected 010", {zero, carry, ovf}); end
        run_op(8'h5A, 8'h5A, 8'h22);
        n_cmp++; if (res !== 8'h00) begin n_err++; $display("FAIL sub_eq_res: got %h expected 00", res); end
        n_cmp++; if ({zero, carry, ovf} !== 3'b100) begin n_err++; $display("FAIL sub_eq_flags: got %b expected 100", {zero, carry, ovf}); end
    endtask

    task automatic test_undef;
        run_op(8'h03, 8'h05, 8'h22);
        run_op(8'h01, 8'h01, 8'h3F);
        n_cmp++; if (res !== 8'h00) begin n_err++; $display("FAIL undef_res: got %h expected 00", res); end
        n_cmp++; if ({zero, carry, ovf} !== 3'b100) begin n_err++; $display("FAIL undef_flags: got %b expected 100", {zero, carry, ovf}); end
        n_cmp++; if (vcount !== 1) begin n_err++; $display("FAIL undef_pulse: got %0d expected 1", vcount); end
    endtask

    task automatic test_logic_shift;
        run_op(8'hF0, 8'h3C, 8'h24);
        n_cmp++; if (res !== 8'h30) begin n_err++; $display("FAIL and_res: got %h expected 30", res); end
        run_op(8'hF0, 8'h3C, 8'h25);
        n_cmp++; if (res !== 8'hFC) begin n_err++; $display("FAIL or_res: got %h expected FC", res); end
        run_op(8'hF0, 8'h3C, 8'h26);
        n_cmp++; if (res !== 8'hCC) begin n_err++; $display("FAIL xor_res: got %h expected CC", res); end
        run_op(8'hF0, 8'h3C, 8'h27);
        n_cmp++; if (res !== 8'h03) begin n_err++; $display("FAIL nor_res: got %h expected 03", res); end
        run_op(8'h80, 8'h03, 8'hC3);
        n_cmp++; if (res !== 8'hF0) begin n_err++; $display("FAIL sra3_res: got %h expected F0", res); end
        run_op(8'h80, 8'h03, 8'h02);
        n_cmp++; if (res !== 8'h10) begin n_err++; $display("FAIL srl3_res: got %h expected 10", res); end
        run_op(8'h80, 8'h09, 8'h03);
        n_cmp++; if (res !== 8'hFF) begin n_err++; $display("FAIL sra9_res: got %h expected FF", res); end
        n_cmp++; if ({zero, carry, ovf} !== 3'b000) begin n_err++; $display("FAIL sra9_flags: got %b expected 000", {zero, carry, ovf}); end
        run_op(8'h80, 8'h09, 8'h02);
        n_cmp++; if (res !== 8'h00) begin n_err++; $display("FAIL srl9_res: got %h expected 00", res); end
        n_cmp++; if (zero !== 1'b1) begin n_err++; $display("FAIL srl9_zero: got %b expected 1", zero); end
    endtask

    task automatic test_hold;
        @(negedge clk);
        sw = 8'h10;
        enter = 1'b1;
        repeat (50) @(negedge clk);
        n_cmp++; if (st !== 2'd1) begin n_err++; $display("FAIL hold_state: got %0d expected 1", st); end
        enter = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++; if (st !== 2'd1) begin n_err++; $display("FAIL hold_release_state: got %0d expected 1", st); end
        press(8'h01);
        press_exec(8'h22);
        n_cmp++; if (res !== 8'h0F) begin n_err++; $display("FAIL hold_sub_res: got %h expected 0F", res); end
    endtask

    task automatic test_reset_mid;
        press(8'h11);
        press(8'h22);
        n_cmp++; if (st !== 2'd2) begin n_err++; $display("FAIL mid_pre_state: got %0d expected 2", st); end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (st !== 2'd0) begin n_err++; $display("FAIL mid_state: got %0d expected 0", st); end
        n_cmp++; if (res !== 8'h00) begin n_err++; $display("FAIL mid_res: got %h expected 00", res); end
        n_cmp++; if ({zero, carry, ovf, valid} !== 4'b0000) begin n_err++; $display("FAIL mid_flags: got %b expected 0000", {zero, carry, ovf, valid}); end
        enter = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        n_cmp++; if (st !== 2'd0) begin n_err++; $display("FAIL held_through_reset: got %0d expected 0", st); end
        enter = 1'b0;
        repeat (5) @(negedge clk);
        run_op(8'h05, 8'h03, 8'h20);
        n_cmp++; if (res !== 8'h08) begin n_err++; $display("FAIL post_reset_res: got %h expected 08", res); end
        n_cmp++; if (vfirst !== 4) begin n_err++; $display("FAIL post_reset_latency: got %0d expected 4", vfirst); end
        n_cmp++; if (vcount !== 1) begin n_err++; $display("FAIL post_reset_pulse: got %0d expected 1", vcount); end
    endtask

    initial begin
        test_reset();
        test_add_basic();
        test_add_overflow();
        test_sub();
        test_undef();
        test_logic_shift();
        test_hold();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Parametrised successor to the board-level ALU wrapper. Operands and opcode are entered from the switch bank through one debounced-edge "enter" button, sequenced by a load state machine instead of one button per register. The block runs a registered ALU operation with status flags and a one-cycle result-valid strobe, and drives board LEDs directly.

## Interface

Parameters:
- NB_DATA, 8: operand/result width; must be ≥ 6.
- NB_OP, 6: opcode width; taken from i_switches[NB_OP-1:0].
- NB_SYNC, 2: synchroniser flops on i_enter; must be ≥ 2.

Ports:
- i_clock, input, 1: single clock; every register is on its rising edge.
- i_reset, input, 1: asynchronous, active-low reset.
- i_switches, input, NB_DATA: operand/opcode source; sampled only on an enter event.
- i_enter, input, 1: asynchronous push-button.
- o_resultado, output, NB_DATA signed: last computed result.
- o_zero, output, 1: result == 0.
- o_carry, output, 1: ADD carry-out / SUB borrow.
- o_overflow, output, 1: signed overflow of ADD/SUB.
- o_valid, output, 1: one-cycle pulse when o_resultado/flags update.
- o_state, output, 2: current FSM state, for LEDs.

## Operation

- i_enter passes through an NB_SYNC-flop synchroniser. enter_evt = synced & ~synced_d: one pulse per press, regardless of hold time.
- FSM states and encodings: LOAD_A=0, LOAD_B=1, LOAD_OP=2, EXEC=3.
  - LOAD_A + enter_evt: A <= i_switches, go to LOAD_B.
  - LOAD_B + enter_evt: B <= i_switches, go to LOAD_OP.
  - LOAD_OP + enter_evt: OP <= i_switches[NB_OP-1:0], go to EXEC.
  - EXEC: unconditional, one cycle. Result and flags are registered, o_valid=1, then back to LOAD_A. An enter_evt arriving in EXEC is dropped.
- Without enter_evt, the state and operand registers hold their values.
- Opcodes (6-bit):
  - ADD 100000
  - SUB 100010
  - AND 100100
  - OR 100101
  - XOR 100110
  - NOR 100111
  - SRA 000011
  - SRL 000010
- Arithmetic:
  - ADD/SUB are computed at NB_DATA+1 bits.
  - carry = bit NB_DATA for ADD. For SUB it is the borrow (A < B unsigned).
  - overflow uses the signed rule: operand signs agree (ADD) or differ (SUB), and the result sign differs from A.
  - carry and overflow are 0 for all non-arithmetic ops.
- Shifts:
  - Shift amount = B, unsigned.
  - Amount ≥ NB_DATA: SRL gives 0, SRA gives all copies of A's sign bit.
- Undefined opcode: result 0, all flags 0, o_zero=1, o_valid still pulses.
- o_zero is computed from the final (post-saturation) result.
- Outputs hold between EXEC cycles.
- Reset values: all outputs 0, A/B/OP 0, synchroniser 0, state LOAD_A.

## Timing

- Raw i_enter rise to enter_evt: NB_SYNC cycles (button held stable).
- enter_evt in LOAD_OP at edge k: state=EXEC during cycle k+1. Outputs update and o_valid is high during cycle k+2; o_state=0 in the same cycle.
- Minimum press-to-press spacing: unconstrained. Every distinct synchronised rising edge outside EXEC is consumed.
- Reset asserted mid-sequence: immediate asynchronous clear of all state. A button held through reset release does not produce enter_evt until it is released and pressed again.

## Configuration

- ALU_SAT_EN defined: on signed overflow, ADD/SUB saturate to 2^(NB_DATA-1)-1 (positive overflow) or -2^(NB_DATA-1) (negative). o_overflow is still 1 and carry is unchanged.
- ALU_SAT_EN undefined: ADD/SUB wrap modulo 2^NB_DATA.

## Test plan

- Reset, then press enter with switches 8'h05, 8'h03, 8'b00100000. o_resultado=8'h08 and o_valid is high exactly one cycle, NB_SYNC+2 cycles after the third press. Flags all 0.
- Sequence A=8'h7F, B=8'h01, ADD: o_overflow=1. Result is 8'h80 without ALU_SAT_EN, 8'h7F with it.
- A=8'h03, B=8'h05, SUB: o_resultado=8'hFE, o_carry=1, o_overflow=0. A=B=8'h5A, SUB: o_zero=1.
- A=8'h80, B=8'h09, SRA: 8'hFF. Same operands with SRL: 8'h00, o_zero=1.
- Hold i_enter for 50 cycles: state advances exactly one step. Opcode 6'b111111: result 0, o_valid pulses.
- Assert i_reset low while in LOAD_OP: o_state=0 and all outputs 0 immediately. Full sequence after release behaves as in the first scenario.
